iob_ibex_bus_arbiter: RTL and testbench



---
 rtl/iob_ibex_arb_pkg.sv | 19 +
 rtl/iob_ibex_arb_fifo.sv | 56 +++++
 rtl/iob_ibex_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_iob_ibex_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_ibex_arb_pkg.sv
// Shared types for the Ibex fetch/LSU bus arbiter.
// Round-robin arbitration is selected by defining IOB_IBEX_ARB_RR_EN.
package iob_ibex_arb_pkg;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_req_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic arb_req_e arb_other(input arb_req_e r);
        return (r == ARB_INSTR) ? ARB_DATA : ARB_INSTR;
    endfunction

endpackage

// File: rtl/iob_ibex_arb_fifo.sv
// 1-bit routing FIFO recording which requester owns each in-flight transaction.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module iob_ibex_arb_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic head_o,
    output logic empty_o,
    output logic full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 0;
    localparam int unsigned IW = (AW > 0) ? AW : 1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [IW-1:0]    widx, ridx;

    assign widx = (AW > 0) ? wptr_q[IW-1:0] : '0;
    assign ridx = (AW > 0) ? rptr_q[IW-1:0] : '0;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = ((wptr_q - rptr_q) == (AW+1)'(DEPTH));
    assign head_o  = mem_q[ridx];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push_i) begin
            mem_d[widx] = data_i;
            wptr_d      = wptr_q + (AW+1)'(1);
        end
        if (pop_i) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Storage is not reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/iob_ibex_bus_arbiter.sv
// Shares one Ibex-protocol memory port between instruction fetch and LSU.
// Define IOB_IBEX_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module iob_ibex_bus_arbiter
    import iob_ibex_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned INTG_W    = 7,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic              instr_err_o,
    output logic [DATA_W-1:0] instr_rdata_o,
    output logic [INTG_W-1:0] instr_rdata_intg_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    input  logic [INTG_W-1:0] data_wdata_intg_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic              data_err_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic [INTG_W-1:0] data_rdata_intg_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [INTG_W-1:0] mem_wdata_intg_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic              mem_err_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [INTG_W-1:0] mem_rdata_intg_i
);

    localparam int unsigned      CNT_W   = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    arb_state_e       state_q, state_d;
    arb_req_e         sel_q, sel_d, sel, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             can_issue, gnt, rsp_ok;
    logic             fifo_head, fifo_empty, fifo_full;

    assign can_issue = (cnt_q < MAX_CNT);

`ifdef IOB_IBEX_ARB_RR_EN
    // rr_q remembers the last granted requester; contention favours the other one.
    arb_req_e rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (gnt) begin
            rr_d = sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= ARB_INSTR;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign pick = (instr_req_i && data_req_i) ? arb_other(rr_q)
                                              : (data_req_i ? ARB_DATA : ARB_INSTR);
`else
    assign pick = data_req_i ? ARB_DATA : ARB_INSTR;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sel       = sel_q;
        mem_req_o = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                sel = pick;
                if (can_issue && (instr_req_i || data_req_i)) begin
                    mem_req_o = 1'b1;
                    if (!mem_gnt_i) begin
                        state_d = ARB_LOCKED;
                        sel_d   = pick;
                    end
                end
            end
            ARB_LOCKED: begin
                // Requests stay asserted until granted, so the held one is still pending.
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            sel_q   <= ARB_INSTR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt    = mem_gnt_i & mem_req_o;
    assign rsp_ok = mem_rvalid_i & ~fifo_empty;

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !rsp_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!gnt && rsp_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    iob_ibex_arb_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (gnt),
        .data_i  (sel == ARB_DATA),
        .pop_i   (rsp_ok),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign instr_gnt_o = gnt & (sel == ARB_INSTR);
    assign data_gnt_o  = gnt & (sel == ARB_DATA);

    assign mem_we_o         = (sel == ARB_DATA) ? data_we_i         : 1'b0;
    assign mem_be_o         = (sel == ARB_DATA) ? data_be_i         : 4'hF;
    assign mem_addr_o       = (sel == ARB_DATA) ? data_addr_i       : instr_addr_i;
    assign mem_wdata_o      = (sel == ARB_DATA) ? data_wdata_i      : '0;
    assign mem_wdata_intg_o = (sel == ARB_DATA) ? data_wdata_intg_i : '0;

    assign instr_rvalid_o = rsp_ok & ~fifo_head;
    assign data_rvalid_o  = rsp_ok &  fifo_head;
    assign instr_err_o    = rsp_ok & ~fifo_head & mem_err_i;
    assign data_err_o     = rsp_ok &  fifo_head & mem_err_i;

    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && fifo_empty))
                else $warning("iob_ibex_bus_arbiter: response with nothing outstanding dropped");
            assert ((cnt_q == MAX_CNT) == fifo_full);
        end
    end
`endif

endmodule

// File: tb/tb_iob_ibex_bus_arbiter.sv
// Directed bench for iob_ibex_bus_arbiter (MAX_OUTST=2); follows IOB_IBEX_ARB_RR_EN.
module tb_iob_ibex_bus_arbiter;

`ifdef IOB_IBEX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst_n;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic [6:0]  instr_rdata_intg;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [6:0]  data_wdata_intg, data_rdata_intg;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [6:0]  mem_wdata_intg, mem_rdata_intg;

    int n_checks = 0;
    int n_fail   = 0;

    iob_ibex_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .INTG_W(7), .MAX_OUTST(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid), .instr_err_o(instr_err),
        .instr_rdata_o(instr_rdata), .instr_rdata_intg_o(instr_rdata_intg),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
        .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid), .data_err_o(data_err),
        .data_rdata_o(data_rdata), .data_rdata_intg_o(data_rdata_intg),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wdata_intg_o(mem_wdata_intg),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
        .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rdata_intg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0;
        data_wdata = '0; data_wdata_intg = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = '0; mem_rdata_intg = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  ng_i, ng_d;
        bit  exp_d, prev_d;

        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_instr_gnt", instr_gnt, 0);
        check("rst_data_gnt", data_gnt, 0);
        check("rst_instr_rvalid", instr_rvalid, 0);
        check("rst_data_rvalid", data_rvalid, 0);
        check("rst_cnt", dut.cnt_q, 0);
        tick();

        // Single fetch
        instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
        @(negedge clk);
        check("fetch_mem_req", mem_req, 1);
        check("fetch_addr", mem_addr, 32'h80);
        check("fetch_be", mem_be, 4'hF);
        check("fetch_we", mem_we, 0);
        check("fetch_wdata", mem_wdata, 0);
        check("fetch_instr_gnt", instr_gnt, 1);
        check("fetch_data_gnt", data_gnt, 0);
        tick();
        idle_inputs();
        mem_rvalid = 1; mem_rdata = 32'h0000_0013; mem_rdata_intg = 7'h2A;
        @(negedge clk);
        check("fetch_instr_rvalid", instr_rvalid, 1);
        check("fetch_data_rvalid", data_rvalid, 0);
        check("fetch_instr_err", instr_err, 0);
        check("fetch_instr_rdata", instr_rdata, 32'h13);
        check("fetch_data_rdata_bcast", data_rdata, 32'h13);
        check("fetch_rdata_intg", instr_rdata_intg, 7'h2A);
        tick();
        idle_inputs();

        // Contention, grant held for 4 cycles; responses keep cnt at 1
        ng_i = 0; ng_d = 0; prev_d = 0;
        for (int i = 0; i < 4; i++) begin
            instr_req = 1; instr_addr = 32'h80;
            data_req = 1; data_addr = 32'h1000;
            mem_gnt = 1; mem_rvalid = (i > 0);
            exp_d = RR ? (i % 2 == 0) : 1'b1;
            @(negedge clk);
            check($sformatf("cont_data_gnt%0d", i), data_gnt, exp_d);
            check($sformatf("cont_instr_gnt%0d", i), instr_gnt, !exp_d);
            check($sformatf("cont_addr%0d", i), mem_addr, exp_d ? 32'h1000 : 32'h80);
            if (i > 0) begin
                check($sformatf("cont_data_rvalid%0d", i), data_rvalid, prev_d);
                check($sformatf("cont_instr_rvalid%0d", i), instr_rvalid, !prev_d);
            end
            ng_i += int'(instr_gnt);
            ng_d += int'(data_gnt);
            prev_d = exp_d;
            tick();
        end
        check("cont_total_data", ng_d, RR ? 2 : 4);
        check("cont_total_instr", ng_i, RR ? 2 : 0);
        idle_inputs();
        mem_rvalid = 1;
        @(negedge clk);
        check("cont_drain_data_rvalid", data_rvalid, prev_d);
        check("cont_drain_instr_rvalid", instr_rvalid, !prev_d);
        tick();
        idle_inputs();
        @(negedge clk);
        check("cont_cnt", dut.cnt_q, 0);
        tick();

        // Lock: data held while instr_req rises, granted on 4th cycle
        for (int i = 0; i < 4; i++) begin
            data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h2000;
            data_wdata = 32'hDEAD_BEEF; data_wdata_intg = 7'h55;
            instr_req = (i > 0); instr_addr = 32'h84;
            mem_gnt = (i == 3);
            @(negedge clk);
            check($sformatf("lock_addr%0d", i), mem_addr, 32'h2000);
            check($sformatf("lock_mem_req%0d", i), mem_req, 1);
            check($sformatf("lock_instr_gnt%0d", i), instr_gnt, 0);
            check($sformatf("lock_data_gnt%0d", i), data_gnt, (i == 3));
            tick();
        end
        idle_inputs();
        instr_req = 0; mem_rvalid = 1;
        @(negedge clk);
        check("lock_data_rvalid", data_rvalid, 1);
        check("lock_instr_rvalid", instr_rvalid, 0);
        tick();
        idle_inputs();

        // Lock write-path fields checked on a fresh granted write
        data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h2004;
        data_wdata = 32'hDEAD_BEEF; data_wdata_intg = 7'h55; mem_gnt = 1;
        @(negedge clk);
        check("wr_we", mem_we, 1);
        check("wr_be", mem_be, 4'h3);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_wdata_intg", mem_wdata_intg, 7'h55);
        tick();
        idle_inputs();
        mem_rvalid = 1;
        @(negedge clk);
        check("wr_data_rvalid", data_rvalid, 1);
        tick();
        idle_inputs();

        // Outstanding limit
        instr_req = 1; instr_addr = 32'h100; mem_gnt = 1;
        @(negedge clk);
        check("lim_gnt1", instr_gnt, 1);
        tick();
        @(negedge clk);
        check("lim_gnt2", instr_gnt, 1);
        tick();
        mem_rvalid = 1;
        @(negedge clk);
        check("lim_full_cnt", dut.cnt_q, 2);
        check("lim_full_mem_req", mem_req, 0);
        check("lim_full_gnt", instr_gnt, 0);
        check("lim_full_rvalid", instr_rvalid, 1);
        tick();
        mem_rvalid = 0;
        @(negedge clk);
        check("lim_reopen_mem_req", mem_req, 1);
        check("lim_reopen_gnt", instr_gnt, 1);
        tick();
        idle_inputs();
        mem_rvalid = 1;
        tick(); tick();
        idle_inputs();
        @(negedge clk);
        check("lim_cnt_drained", dut.cnt_q, 0);
        tick();

        // Ordering and error routing
        instr_req = 1; instr_addr = 32'h200; mem_gnt = 1;
        @(negedge clk);
        check("ord_instr_gnt", instr_gnt, 1);
        tick();
        idle_inputs();
        data_req = 1; data_addr = 32'h3000; mem_gnt = 1;
        @(negedge clk);
        check("ord_data_gnt", data_gnt, 1);
        tick();
        idle_inputs();
        mem_rvalid = 1; mem_err = 0;
        @(negedge clk);
        check("ord_r1_instr_rvalid", instr_rvalid, 1);
        check("ord_r1_instr_err", instr_err, 0);
        check("ord_r1_data_rvalid", data_rvalid, 0);
        tick();
        mem_rvalid = 1; mem_err = 1;
        @(negedge clk);
        check("ord_r2_data_rvalid", data_rvalid, 1);
        check("ord_r2_data_err", data_err, 1);
        check("ord_r2_instr_rvalid", instr_rvalid, 0);
        check("ord_r2_instr_err", instr_err, 0);
        tick();
        idle_inputs();

        // Reset with two outstanding
        instr_req = 1; instr_addr = 32'h300; mem_gnt = 1;
        tick();
        idle_inputs();
        data_req = 1; data_addr = 32'h4000; mem_gnt = 1;
        tick();
        idle_inputs();
        @(negedge clk);
        check("rst2_cnt_before", dut.cnt_q, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1;
        @(negedge clk);
        check("rst2_instr_rvalid", instr_rvalid, 0);
        check("rst2_data_rvalid", data_rvalid, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("rst2_cnt", dut.cnt_q, 0);
        tick();
        instr_req = 1; instr_addr = 32'h400; mem_gnt = 1;
        @(negedge clk);
        check("rst2_new_mem_req", mem_req, 1);
        check("rst2_new_gnt", instr_gnt, 1);
        tick();
        idle_inputs();
        mem_rvalid = 1;
        @(negedge clk);
        check("rst2_new_rvalid", instr_rvalid, 1);
        tick();
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
